// File: rtl/perceptron_predict_unit.sv
// perceptron_predict_unit
// -----------------------------------------------------------------------------
// Upstream stage of the perceptron trainer. It owns the perceptron weight table
// and the speculative global history register. A lookup snapshots one weight row
// and the current history, then folds the dot product over several cycles,
// LANES weights at a time. The result goes out with the index and history
// snapshot so the trainer can update the same row later.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/ready     lookup handshake; req_pc[INDEX+1:2] selects the row
//   rsp_valid/ready     prediction handshake
//   rsp_taken           predicted direction (sum >= 0)
//   rsp_sum             signed dot product
//   rsp_index           row used for this prediction
//   rsp_history         history snapshot used for this prediction
//   hist_push_*         speculative history shift
//   hist_restore_*      history recovery after a misprediction (wins over push)
//   wr_valid/index/weights  full-row writeback from the trainer
// -----------------------------------------------------------------------------
module perceptron_predict_unit #(
   parameter int HISTORY_SIZE      = 16,
   parameter int INDEX             = 6,
   parameter int PERCEPTRON_NUMBER = 64,
   parameter int WIDTH             = 8,
   parameter int SUM_WIDTH         = 16,
   parameter int LANES             = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [31:0]                       req_pc,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic                              rsp_taken,
   output logic signed [SUM_WIDTH-1:0]       rsp_sum,
   output logic [INDEX-1:0]                  rsp_index,
   output logic [HISTORY_SIZE-1:0]           rsp_history,
   input  logic                              hist_push_valid,
   input  logic                              hist_push_taken,
   input  logic                              hist_restore_valid,
   input  logic [HISTORY_SIZE-1:0]           hist_restore_value,
   input  logic                              wr_valid,
   input  logic [INDEX-1:0]                  wr_index,
   input  logic [(HISTORY_SIZE+1)*WIDTH-1:0] wr_weights
);

   localparam int ROW_W   = (HISTORY_SIZE + 1) * WIDTH;
   localparam int K       = (HISTORY_SIZE + LANES - 1) / LANES;
   localparam int G_W     = (K > 1) ? $clog2(K) : 1;
   localparam int TERMS   = K * LANES;
   localparam int WORK_W  = (TERMS + 1) * WIDTH;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                       state_q, state_d;
   logic [ROW_W-1:0]             table_q [PERCEPTRON_NUMBER];
   logic [HISTORY_SIZE-1:0]      history_q;
   logic [HISTORY_SIZE-1:0]      snap_hist_q;
   logic [INDEX-1:0]             snap_index_q;
   logic [WORK_W-1:0]            work_row_q;
   logic [TERMS-1:0]             work_hist_q;
   logic signed [SUM_WIDTH-1:0]  acc_q;
   logic [G_W-1:0]               group_q;

   logic [INDEX-1:0]             req_index;
   logic [ROW_W-1:0]             req_row;
   logic signed [SUM_WIDTH-1:0]  bias_ext;
   logic                         accept;
   logic                         last_group;
   logic                         done;
   logic signed [SUM_WIDTH-1:0]  lane_term [LANES];
   logic signed [SUM_WIDTH-1:0]  lane_partial [LANES];
   logic                         unused_pc;

   assign req_index  = req_pc[INDEX+1:2];
   assign unused_pc  = ^{req_pc[31:INDEX+2], req_pc[1:0]};
   assign req_row    = table_q[req_index];
   assign bias_ext   = {{(SUM_WIDTH-WIDTH){req_row[WIDTH-1]}}, req_row[WIDTH-1:0]};
   assign accept     = (state_q == IDLE) && req_valid;
   assign last_group = (group_q == G_W'(K - 1));
   assign done       = (state_q == DONE);

   // The working copy of the row and history is shifted down by one group
   // every ACCUM cycle, so each lane always reads a fixed slot. Slots past the
   // last real weight are zero-padded, which makes those lanes contribute 0.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [WIDTH-1:0]            lane_w;
      logic signed [SUM_WIDTH-1:0] lane_ext;
      assign lane_w   = work_row_q[(l+1)*WIDTH +: WIDTH];
      assign lane_ext = {{(SUM_WIDTH-WIDTH){lane_w[WIDTH-1]}}, lane_w};
      assign lane_term[l] = work_hist_q[l] ? lane_ext : -lane_ext;
      if (l == 0) begin : g_first
         assign lane_partial[l] = lane_term[l];
      end else begin : g_rest
         assign lane_partial[l] = lane_partial[l-1] + lane_term[l];
      end
   end

   // Next-state logic: one ACCUM cycle per lane group, then hold in DONE
   // until the consumer takes the prediction.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid)  state_d = ACCUM;
         ACCUM:   if (last_group) state_d = DONE;
         DONE:    if (rsp_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus the lookup datapath. The snapshot is taken from the
   // table and history registers as they were before this edge, so a write or
   // history update in the accept cycle is not seen by this lookup.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         snap_hist_q  <= '0;
         snap_index_q <= '0;
         work_row_q   <= '0;
         work_hist_q  <= '0;
         acc_q        <= '0;
         group_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            snap_hist_q  <= history_q;
            snap_index_q <= req_index;
            work_row_q   <= WORK_W'(req_row);
            work_hist_q  <= TERMS'(history_q);
            acc_q        <= bias_ext;
            group_q      <= '0;
         end else if (state_q == ACCUM) begin
            acc_q       <= acc_q + lane_partial[LANES-1];
            work_row_q  <= work_row_q >> (LANES * WIDTH);
            work_hist_q <= work_hist_q >> LANES;
            group_q     <= group_q + G_W'(1);
         end
      end
   end

   // Weight table: full-row writes from the trainer, accepted in any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PERCEPTRON_NUMBER; i++) begin
            table_q[i] <= '0;
         end
      end else if (wr_valid) begin
         table_q[wr_index] <= wr_weights;
      end
   end

   // Speculative global history. Restore takes priority over a push; the
   // newest outcome enters at bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         history_q <= '0;
      end else if (hist_restore_valid) begin
         history_q <= hist_restore_value;
      end else if (hist_push_valid) begin
         history_q <= {history_q[HISTORY_SIZE-2:0], hist_push_taken};
      end
   end

   // Response outputs read as zero outside DONE so nothing partial leaks out
   // while the sum is still being accumulated.
   assign req_ready   = (state_q == IDLE);
   assign rsp_valid   = done;
   assign rsp_sum     = done ? acc_q : '0;
   assign rsp_taken   = done && !acc_q[SUM_WIDTH-1];
   assign rsp_index   = done ? snap_index_q : '0;
   assign rsp_history = done ? snap_hist_q : '0;

endmodule

// File: tb/tb_perceptron_predict_unit.sv
// tb_perceptron_predict_unit
// -----------------------------------------------------------------------------
// Self-checking bench for perceptron_predict_unit. A behavioural model keeps the
// weight table and history as plain integers and computes each prediction as a
// straight sum over the row. Directed cases cover the corner behaviour, then a
// randomized phase mixes lookups with writes and history traffic.
// -----------------------------------------------------------------------------
module tb_perceptron_predict_unit;

   localparam int HS    = 16;
   localparam int IDX   = 6;
   localparam int ROWS  = 64;
   localparam int W     = 8;
   localparam int SW    = 16;
   localparam int LANES = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req_valid;
   logic                   req_ready;
   logic [31:0]            req_pc;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_taken;
   logic signed [SW-1:0]   rsp_sum;
   logic [IDX-1:0]         rsp_index;
   logic [HS-1:0]          rsp_history;
   logic                   hist_push_valid;
   logic                   hist_push_taken;
   logic                   hist_restore_valid;
   logic [HS-1:0]          hist_restore_value;
   logic                   wr_valid;
   logic [IDX-1:0]         wr_index;
   logic [(HS+1)*W-1:0]    wr_weights;

   int model_w [ROWS][HS+1];
   int model_hist;
   int pend [HS+1];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   perceptron_predict_unit #(
      .HISTORY_SIZE(HS), .INDEX(IDX), .PERCEPTRON_NUMBER(ROWS),
      .WIDTH(W), .SUM_WIDTH(SW), .LANES(LANES)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_taken(rsp_taken),
      .rsp_sum(rsp_sum), .rsp_index(rsp_index), .rsp_history(rsp_history),
      .hist_push_valid(hist_push_valid), .hist_push_taken(hist_push_taken),
      .hist_restore_valid(hist_restore_valid), .hist_restore_value(hist_restore_value),
      .wr_valid(wr_valid), .wr_index(wr_index), .wr_weights(wr_weights)
   );

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference prediction: bias plus +w or -w per history bit.
   function automatic int predict(input int idx, input int h);
      int s;
      s = model_w[idx][0];
      for (int t = 1; t <= HS; t++) begin
         if (((h >> (t - 1)) & 1) == 1) s += model_w[idx][t];
         else                           s -= model_w[idx][t];
      end
      return s;
   endfunction

   function automatic int randWeight();
      return int'($urandom_range(255)) - 128;
   endfunction

   task automatic modelReset();
      for (int r = 0; r < ROWS; r++)
         for (int j = 0; j <= HS; j++) model_w[r][j] = 0;
      model_hist = 0;
   endtask

   task automatic packPending();
      for (int j = 0; j <= HS; j++) wr_weights[j*W +: W] = 8'(pend[j]);
   endtask

   task automatic randomPending();
      for (int j = 0; j <= HS; j++) pend[j] = randWeight();
   endtask

   task automatic commitPending(input int idx);
      for (int j = 0; j <= HS; j++) model_w[idx][j] = pend[j];
   endtask

   task automatic writeRow(input int idx);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_index = 6'(idx);
      packPending();
      @(negedge clk);
      wr_valid = 1'b0;
      commitPending(idx);
   endtask

   task automatic setHistory(input int v);
      @(negedge clk);
      hist_restore_valid = 1'b1;
      hist_restore_value = 16'(v);
      @(negedge clk);
      hist_restore_valid = 1'b0;
      model_hist = v & 16'hFFFF;
   endtask

   task automatic pushHistory(input bit b);
      @(negedge clk);
      hist_push_valid = 1'b1;
      hist_push_taken = b;
      @(negedge clk);
      hist_push_valid = 1'b0;
      model_hist = ((model_hist << 1) | int'(b)) & 16'hFFFF;
   endtask

   // One full lookup: optional write/push in the accept cycle, optional random
   // history and table traffic while the lookup is in flight, and an optional
   // hold in DONE with writes to the same row.
   task automatic applyStimulus(input logic [31:0] pc, input int hold, input bit sideWr,
                                input bit sidePush, input bit sideBit, input bit noise);
      int  idx, exp_sum, exp_hist, cyc;
      bit  seen;
      bit  nw, np, nr;
      int  nidx, nval;
      bit  nb;
      idx = int'(pc[7:2]);
      @(negedge clk);
      checkOutput("req_ready_idle", 32'(req_ready), 1);
      exp_sum  = predict(idx, model_hist);
      exp_hist = model_hist;
      req_valid = 1'b1;
      req_pc    = pc;
      if (sideWr) begin
         wr_valid = 1'b1;
         wr_index = 6'(idx);
         packPending();
      end
      if (sidePush) begin
         hist_push_valid = 1'b1;
         hist_push_taken = sideBit;
      end
      @(negedge clk);
      req_valid       = 1'b0;
      req_pc          = $urandom;
      wr_valid        = 1'b0;
      hist_push_valid = 1'b0;
      if (sideWr) commitPending(idx);
      if (sidePush) model_hist = ((model_hist << 1) | int'(sideBit)) & 16'hFFFF;
      cyc  = 1;
      seen = 1'b0;
      while (cyc <= 20 && !seen) begin
         if (rsp_valid === 1'b1) begin
            seen = 1'b1;
         end else begin
            nw = 1'b0; np = 1'b0; nr = 1'b0; nidx = 0; nval = 0; nb = 1'b0;
            if (noise) begin
               nw = 1'($urandom_range(1));
               np = 1'($urandom_range(1));
               nr = ($urandom_range(3) == 0);
               nb = 1'($urandom_range(1));
               nidx = (nw && $urandom_range(1) == 1) ? idx : int'($urandom_range(7));
               nval = int'($urandom_range(16'hFFFF));
               randomPending();
               wr_valid = nw; wr_index = 6'(nidx); packPending();
               hist_push_valid = np; hist_push_taken = nb;
               hist_restore_valid = nr; hist_restore_value = 16'(nval);
            end
            @(negedge clk);
            wr_valid = 1'b0; hist_push_valid = 1'b0; hist_restore_valid = 1'b0;
            if (nw) commitPending(nidx);
            if (nr) model_hist = nval;
            else if (np) model_hist = ((model_hist << 1) | int'(nb)) & 16'hFFFF;
            cyc++;
         end
      end
      checkOutput("rsp_valid_seen", 32'(seen), 1);
      if (!seen) return;
      checkOutput("latency", cyc, 5);
      checkOutput("rsp_sum", 32'(rsp_sum), exp_sum);
      checkOutput("rsp_taken", 32'(rsp_taken), (exp_sum >= 0) ? 1 : 0);
      checkOutput("rsp_index", 32'(rsp_index), idx);
      checkOutput("rsp_history", 32'(rsp_history), exp_hist);
      for (int h = 0; h < hold; h++) begin
         randomPending();
         wr_valid = 1'b1; wr_index = 6'(idx); packPending();
         @(negedge clk);
         wr_valid = 1'b0;
         commitPending(idx);
         checkOutput("hold_valid", 32'(rsp_valid), 1);
         checkOutput("hold_sum", 32'(rsp_sum), exp_sum);
         checkOutput("hold_history", 32'(rsp_history), exp_hist);
         checkOutput("hold_req_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_drop", 32'(rsp_valid), 0);
      checkOutput("req_ready_back", 32'(req_ready), 1);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
      hist_push_valid = 1'b0; hist_push_taken = 1'b0;
      hist_restore_valid = 1'b0; hist_restore_value = '0;
      wr_valid = 1'b0; wr_index = '0; wr_weights = '0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("reset_req_ready", 32'(req_ready), 1);
      checkOutput("reset_rsp_sum", 32'(rsp_sum), 0);

      // All-zero table lookup.
      applyStimulus(32'h40, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Bias 3, weights 2, all-taken history, then all-not-taken history.
      pend[0] = 3;
      for (int j = 1; j <= HS; j++) pend[j] = 2;
      writeRow(16);
      setHistory(16'hFFFF);
      applyStimulus(32'h40, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      setHistory(16'h0000);
      applyStimulus(32'h40, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Most negative row: checks the accumulator does not wrap.
      for (int j = 0; j <= HS; j++) pend[j] = -128;
      writeRow(16);
      setHistory(16'hFFFF);
      applyStimulus(32'h40, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Write and push in the accept cycle: old row and history used now,
      // new ones on the next lookup.
      randomPending();
      applyStimulus(32'h40, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(32'h40, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Long hold in DONE with writes to the same row.
      randomPending();
      writeRow(17);
      applyStimulus(32'h44, 10, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of ACCUM.
      randomPending();
      writeRow(16);
      setHistory(16'hA5A5);
      @(negedge clk);
      req_valid = 1'b1; req_pc = 32'h40;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      checkOutput("midreset_req_ready", 32'(req_ready), 1);
      checkOutput("midreset_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("midreset_rsp_sum", 32'(rsp_sum), 0);
      applyStimulus(32'h40, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'h44, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized mix of lookups, writes and history traffic.
      for (int it = 0; it < 40; it++) begin
         int sel, ridx;
         logic [31:0] pc;
         sel = int'($urandom_range(3));
         if (sel == 0) begin
            randomPending();
            writeRow(int'($urandom_range(7)));
         end else if (sel == 1) begin
            setHistory(int'($urandom_range(16'hFFFF)));
         end else if (sel == 2) begin
            pushHistory(1'($urandom_range(1)));
         end
         ridx = int'($urandom_range(7));
         pc = ($urandom & 32'hFFFF_FF03) | (32'(ridx) << 2);
         randomPending();
         applyStimulus(pc, int'($urandom_range(3)), 1'($urandom_range(1)),
                       1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Backstop so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
